// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
// Shared types and default constants for the period meter.
//   pm_state_e         : measurement FSM states (IDLE, ARM, MEASURE)
//   DEFAULT_WIDTH      : default counter / result width
//   DEFAULT_TIMEOUT    : default cycles without a rising edge before Timeout
//   DEFAULT_FILTER_LEN : default glitch-filter length (PERIOD_METER_FILTER_EN)
// -----------------------------------------------------------------------------
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } pm_state_e;

  localparam int unsigned DEFAULT_WIDTH      = 32'd32;
  localparam int unsigned DEFAULT_TIMEOUT    = 32'd50_000_000;
  localparam int unsigned DEFAULT_FILTER_LEN = 32'd4;

endpackage

// File: rtl/period_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings the asynchronous Sig_In into the Clk_In domain and produces
// single-cycle rise / fall strobes of the synchronized level.
// Optional build macro: PERIOD_METER_FILTER_EN inserts a glitch filter after
// the second synchronizer flop; the filtered level only follows the input
// after FILTER_LEN consecutive cycles at the new value.
// Ports:
//   Clk_In  in   system clock (rising edge)
//   Reset_n in   asynchronous active-low reset
//   Sig_In  in   asynchronous input under measurement
//   rise    out  one-cycle strobe on a 0->1 transition of the level
//   fall    out  one-cycle strobe on a 1->0 transition of the level
// -----------------------------------------------------------------------------
module edge_sync
  import period_meter_pkg::*;
`ifdef PERIOD_METER_FILTER_EN
  #(
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
  )
`endif
  (
    input  logic Clk_In,
    input  logic Reset_n,
    input  logic Sig_In,
    output logic rise,
    output logic fall
  );

  logic s1_r;
  logic s2_r;
  logic s3_r;
  logic lvl_s;

  // two-flop synchronizer for the asynchronous input
  always_ff @(posedge Clk_In or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= Sig_In;
      s2_r <= s1_r;
    end
  end

`ifdef PERIOD_METER_FILTER_EN
  localparam int unsigned FCW = (FILTER_LEN > 32'd1) ? $clog2(FILTER_LEN) : 32'd1;

  logic [FCW-1:0] fcnt_r;
  logic [FCW-1:0] fcnt_s;
  logic           filt_r;
  logic           filt_s;

  // count consecutive cycles the synchronized level disagrees with the
  // filtered level; flip only once the disagreement has lasted FILTER_LEN
  always_comb begin
    fcnt_s = fcnt_r;
    filt_s = filt_r;
    if (s2_r != filt_r) begin
      if (fcnt_r == FCW'(FILTER_LEN - 32'd1)) begin
        filt_s = s2_r;
        fcnt_s = '0;
      end else begin
        fcnt_s = fcnt_r + FCW'(1);
      end
    end else begin
      fcnt_s = '0;
    end
  end

  // glitch-filter state
  always_ff @(posedge Clk_In or negedge Reset_n) begin
    if (!Reset_n) begin
      fcnt_r <= '0;
      filt_r <= 1'b0;
    end else begin
      fcnt_r <= fcnt_s;
      filt_r <= filt_s;
    end
  end

  assign lvl_s = filt_r;
`else
  assign lvl_s = s2_r;
`endif

  // delayed copy of the level for edge detection
  always_ff @(posedge Clk_In or negedge Reset_n) begin
    if (!Reset_n) begin
      s3_r <= 1'b0;
    end else begin
      s3_r <= lvl_s;
    end
  end

  assign rise = lvl_s & ~s3_r;
  assign fall = ~lvl_s & s3_r;

endmodule

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Measures period (rise to rise) and high time (rise to fall) of a slow
// square wave in Clk_In cycles and reports one result per input period.
// Optional build macro: PERIOD_METER_FILTER_EN (glitch filter in edge_sync,
// length FILTER_LEN; adds FILTER_LEN cycles of latency, values unchanged).
// Ports:
//   Clk_In    in   system clock (rising edge)
//   Reset_n   in   asynchronous active-low reset
//   Enable    in   measurement enable; low holds the block idle
//   Sig_In    in   asynchronous signal under measurement
//   Period    out  WIDTH  cycles between consecutive rising edges
//   High_Time out  WIDTH  cycles from a rising edge to the next falling edge
//   Valid     out  one-cycle pulse when Period / High_Time update
//   Timeout   out  sticky: no rising edge within TIMEOUT cycles
// -----------------------------------------------------------------------------
module period_meter
  import period_meter_pkg::*;
  #(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN
  )
  (
    input  logic             Clk_In,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic             Sig_In,
    output logic [WIDTH-1:0] Period,
    output logic [WIDTH-1:0] High_Time,
    output logic             Valid,
    output logic             Timeout
  );

  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

  logic rise_s;
  logic fall_s;

  pm_state_e        state_r;
  pm_state_e        state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] hi_s;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] period_s;
  logic [WIDTH-1:0] high_time_r;
  logic [WIDTH-1:0] high_time_s;
  logic             valid_r;
  logic             valid_s;
  logic             timeout_r;
  logic             timeout_s;

`ifdef PERIOD_METER_FILTER_EN
  edge_sync #(
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_sync (
    .Clk_In  (Clk_In),
    .Reset_n (Reset_n),
    .Sig_In  (Sig_In),
    .rise    (rise_s),
    .fall    (fall_s)
  );
`else
  edge_sync u_edge_sync (
    .Clk_In  (Clk_In),
    .Reset_n (Reset_n),
    .Sig_In  (Sig_In),
    .rise    (rise_s),
    .fall    (fall_s)
  );
`endif

  // next-state, counter and result logic
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    hi_s        = hi_r;
    period_s    = period_r;
    high_time_s = high_time_r;
    valid_s     = 1'b0;
    timeout_s   = timeout_r;

    if (!Enable) begin
      // abandon any partial measurement; results are kept
      state_s   = IDLE;
      cnt_s     = '0;
      hi_s      = '0;
      timeout_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s   = '0;
          state_s = ARM;
        end
        ARM: begin
          // first edge only starts the count, no result yet
          if (rise_s) begin
            cnt_s   = WIDTH'(1);
            state_s = MEASURE;
          end else if (cnt_r == TIMEOUT_C) begin
            timeout_s = 1'b1;
            cnt_s     = '0;
          end else begin
            cnt_s = cnt_r + WIDTH'(1);
          end
        end
        MEASURE: begin
          // a rise on the timeout cycle still counts as a measurement
          if (rise_s) begin
            period_s    = cnt_r;
            high_time_s = hi_r;
            valid_s     = 1'b1;
            timeout_s   = 1'b0;
            cnt_s       = WIDTH'(1);
          end else if (cnt_r == TIMEOUT_C) begin
            timeout_s = 1'b1;
            cnt_s     = '0;
            state_s   = ARM;
          end else begin
            cnt_s = cnt_r + WIDTH'(1);
            if (fall_s) begin
              hi_s = cnt_r;
            end else begin
              hi_s = hi_r;
            end
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // state, counter and result registers
  always_ff @(posedge Clk_In or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      hi_r        <= '0;
      period_r    <= '0;
      high_time_r <= '0;
      valid_r     <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      hi_r        <= hi_s;
      period_r    <= period_s;
      high_time_r <= high_time_s;
      valid_r     <= valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign Period    = period_r;
  assign High_Time = high_time_r;
  assign Valid     = valid_r;
  assign Timeout   = timeout_r;

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
// Self-checking bench for period_meter. Expected results are derived from the
// waveform being driven: every rising edge that follows an earlier rising edge
// (within TIMEOUT cycles, while enabled) yields the cycle distance between the
// two edges and the high time of the earlier pulse, due a fixed latency after
// the edge is driven.
// -----------------------------------------------------------------------------
module tb_period_meter;

  localparam int unsigned W  = 32;
  localparam int unsigned TO = 100;
  localparam int unsigned FL = 4;
`ifdef PERIOD_METER_FILTER_EN
  localparam int LAT  = 3 + FL;
  localparam int MINW = FL;
  localparam int GLITCH_P = 40;
`else
  localparam int LAT  = 3;
  localparam int MINW = 1;
  localparam int GLITCH_P = 24;
`endif

  logic         Clk_In = 1'b0;
  logic         Reset_n;
  logic         Enable;
  logic         Sig_In;
  logic [W-1:0] Period;
  logic [W-1:0] High_Time;
  logic         Valid;
  logic         Timeout;

  period_meter #(
    .WIDTH      (W),
    .TIMEOUT    (TO),
    .FILTER_LEN (FL)
  ) dut (
    .Clk_In    (Clk_In),
    .Reset_n   (Reset_n),
    .Enable    (Enable),
    .Sig_In    (Sig_In),
    .Period    (Period),
    .High_Time (High_Time),
    .Valid     (Valid),
    .Timeout   (Timeout)
  );

  always #5 Clk_In = ~Clk_In;

  typedef struct {
    int p;
    int h;
    int due;
  } res_t;

  res_t         exp_q[$];
  int           checks    = 0;
  int           failures  = 0;
  int           cyc       = 0;
  int           last_rise = 0;
  int           hi_len    = 0;
  bit           have_prev = 1'b0;
  logic [W-1:0] exp_period = '0;
  logic [W-1:0] exp_high   = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // advance one clock, sample 1 time unit after the edge and check outputs
  task automatic tick();
    res_t r;
    @(posedge Clk_In);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      exp_period = W'(r.p);
      exp_high   = W'(r.h);
      chk("valid_due", W'(Valid), W'(1));
      chk("period", Period, exp_period);
      chk("high_time", High_Time, exp_high);
    end else begin
      chk("valid_quiet", W'(Valid), W'(0));
      chk("period_hold", Period, exp_period);
      chk("high_hold", High_Time, exp_high);
    end
  endtask

  // drive the input level and update the reference model
  task automatic drive_sig(input logic v);
    if (v && !Sig_In && Enable) begin
      if (have_prev && (cyc - last_rise) <= int'(TO))
        exp_q.push_back('{cyc - last_rise, hi_len, cyc + LAT});
      have_prev = 1'b1;
      last_rise = cyc;
    end else if (!v && Sig_In) begin
      hi_len = cyc - last_rise;
    end
    Sig_In = v;
  endtask

  task automatic hold(input logic v, input int n);
    drive_sig(v);
    repeat (n) tick();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    repeat (n) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask

  task automatic set_en(input logic v);
    Enable    = v;
    have_prev = 1'b0;
  endtask

  initial begin
    int t0;
    int hi;
    int lo;

    Reset_n = 1'b0;
    Enable  = 1'b0;
    Sig_In  = 1'b0;
    repeat (3) tick();
    chk("rst_timeout", W'(Timeout), W'(0));
    Reset_n = 1'b1;
    repeat (2) tick();

    // divide-by-4 source: toggles every 2 cycles
    set_en(1'b1);
    hold(1'b0, 4);
    wave(2, 2, 8);
    hold(1'b0, 10);
    chk("div4_drain", W'(exp_q.size()), W'(0));
    chk("div4_period", Period, W'(4));
    chk("div4_high", High_Time, W'(2));

    // 10 high / 30 low, then abort a period by dropping Enable
    wave(10, 30, 5);
    hold(1'b1, 10);
    hold(1'b0, 12);
    chk("w40_period", Period, W'(40));
    chk("w40_high", High_Time, W'(10));
    set_en(1'b0);
    hold(1'b0, 8);
    chk("abort_timeout", W'(Timeout), W'(0));
    set_en(1'b1);
    hold(1'b0, 4);
    chk("abort_kept", Period, W'(40));
    wave(7, 9, 4);
    hold(1'b0, 12);
    chk("rearm_period", Period, W'(16));
    chk("rearm_high", High_Time, W'(7));

    // timeout after a lone rising edge
    set_en(1'b0);
    hold(1'b0, 4);
    set_en(1'b1);
    hold(1'b0, 2);
    t0 = cyc;
    hold(1'b1, 5);
    drive_sig(1'b0);
    while (cyc < t0 + LAT + 99) tick();
    chk("timeout_before", W'(Timeout), W'(0));
    tick();
    chk("timeout_set", W'(Timeout), W'(1));
    hold(1'b0, 20);
    chk("timeout_sticky", W'(Timeout), W'(1));
    hold(1'b1, 6);
    hold(1'b0, 14);
    chk("timeout_arm", W'(Timeout), W'(1));
    hold(1'b1, 6);
    hold(1'b0, 10);
    chk("timeout_clear", W'(Timeout), W'(0));
    chk("timeout_period", Period, W'(20));

    // minimum-width pulses, then random square waves
    wave(MINW, MINW, 4);
    for (int i = 0; i < 30; i++) begin
      hi = int'($urandom_range(25, MINW));
      lo = int'($urandom_range(25, MINW));
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
    hold(1'b0, 12);
    chk("rand_drain", W'(exp_q.size()), W'(0));

    // 2-cycle glitch in the low phase of a 40-cycle wave
    wave(10, 30, 2);
    hold(1'b1, 10);
    hold(1'b0, 14);
`ifdef PERIOD_METER_FILTER_EN
    Sig_In = 1'b1;
    repeat (2) tick();
    Sig_In = 1'b0;
`else
    hold(1'b1, 2);
    drive_sig(1'b0);
`endif
    repeat (14) tick();
    chk("glitch_period", Period, W'(GLITCH_P));
    wave(10, 30, 2);
    hold(1'b0, 12);
    chk("glitch_drain", W'(exp_q.size()), W'(0));

    // asynchronous reset in the middle of a measurement
    hold(1'b1, 10);
    hold(1'b0, 8);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_period", Period, W'(0));
    chk("arst_high", High_Time, W'(0));
    chk("arst_valid", W'(Valid), W'(0));
    chk("arst_timeout", W'(Timeout), W'(0));
    exp_period = '0;
    exp_high   = '0;
    have_prev  = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    Reset_n = 1'b1;
    hold(1'b0, 4);
    wave(6, 10, 4);
    hold(1'b0, 12);
    chk("arst_restart", Period, W'(16));
    chk("arst_restart_high", High_Time, W'(6));
    chk("final_drain", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
